// File: rtl/ahb_bus_matrix_out_stage_n.sv
// ahb_bus_matrix_out_stage_n
//   Output stage of the AHB bus matrix, one instance per shared slave port.
//   Arbitrates between the held transfers of NUM_PORTS input stages, drives
//   the winner's address/control to the slave, then the write data of the
//   port that owns the data phase. Generates HREADYMUXM and per-port active
//   flags. Bursts (BUSY/SEQ) and locked sequences keep the current grant.
//
//   Configuration macro: AHB_OUT_STAGE_FIXED_PRIO_EN
//     defined   -> lowest requesting port index wins a free arbitration
//     undefined -> round-robin, previous winner ranks last
//
// Ports
//   HCLK, HRESETn         clock, synchronous active-low reset
//   sel_op/held_tran_op/write_op/mastlock_op   per-port HSEL/HeldTran/HWRITE/HMASTLOCK
//   trans_op/size_op/burst_op/prot_op/master_op per-port HTRANS/HSIZE/HBURST/HPROT/HMASTER
//   addr_op/auser_op/wdata_op/wuser_op         per-port HADDR/HAUSER/HWDATA/HWUSER
//   HREADYOUTM            slave HREADYOUT
//   active_op             one-hot, port owning the address phase
//   H*M                   muxed slave-side AHB signals, HREADYMUXM ready
module ahb_bus_matrix_out_stage_n #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned USER_W    = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_PORTS-1:0]          sel_op,
  input  logic [NUM_PORTS-1:0]          held_tran_op,
  input  logic [NUM_PORTS-1:0]          write_op,
  input  logic [NUM_PORTS-1:0]          mastlock_op,
  input  logic [2*NUM_PORTS-1:0]        trans_op,
  input  logic [3*NUM_PORTS-1:0]        size_op,
  input  logic [3*NUM_PORTS-1:0]        burst_op,
  input  logic [4*NUM_PORTS-1:0]        prot_op,
  input  logic [4*NUM_PORTS-1:0]        master_op,
  input  logic [ADDR_W*NUM_PORTS-1:0]   addr_op,
  input  logic [USER_W*NUM_PORTS-1:0]   auser_op,
  input  logic [USER_W*NUM_PORTS-1:0]   wuser_op,
  input  logic [DATA_W*NUM_PORTS-1:0]   wdata_op,
  input  logic                          HREADYOUTM,
  output logic [NUM_PORTS-1:0]          active_op,
  output logic                          HSELM,
  output logic                          HWRITEM,
  output logic                          HMASTLOCKM,
  output logic                          HREADYMUXM,
  output logic [1:0]                    HTRANSM,
  output logic [2:0]                    HSIZEM,
  output logic [2:0]                    HBURSTM,
  output logic [3:0]                    HPROTM,
  output logic [3:0]                    HMASTERM,
  output logic [ADDR_W-1:0]             HADDRM,
  output logic [USER_W-1:0]             HAUSERM,
  output logic [DATA_W-1:0]             HWDATAM,
  output logic [USER_W-1:0]             HWUSERM
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_e;

  logic [PORT_W-1:0]    addr_in_port_q, addr_in_port_d;
  logic                 no_port_q, no_port_d;
  logic [PORT_W-1:0]    data_in_port_q;
  logic                 slave_sel_q;
  logic                 hsel_lock_q, hsel_lock_d;
  logic [NUM_PORTS-1:0] req;
  logic                 hlock_arb;
  logic                 burst_hold;
  logic                 found;
  int unsigned          rr_idx;

  assign req        = held_tran_op & sel_op;
  assign HREADYMUXM = slave_sel_q ? HREADYOUTM : 1'b1;

  // Address/control mux: all zero when no port owns the address phase.
  always_comb begin
    active_op  = '0;
    HSELM      = 1'b0;
    HWRITEM    = 1'b0;
    HMASTLOCKM = 1'b0;
    HTRANSM    = '0;
    HSIZEM     = '0;
    HBURSTM    = '0;
    HPROTM     = '0;
    HMASTERM   = '0;
    HADDRM     = '0;
    HAUSERM    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!no_port_q && (addr_in_port_q == PORT_W'(i))) begin
        active_op[i] = 1'b1;
        HSELM        = sel_op[i];
        HWRITEM      = write_op[i];
        HMASTLOCKM   = mastlock_op[i];
        HTRANSM      = trans_op[2*i +: 2];
        HSIZEM       = size_op[3*i +: 3];
        HBURSTM      = burst_op[3*i +: 3];
        HPROTM       = prot_op[4*i +: 4];
        HMASTERM     = master_op[4*i +: 4];
        HADDRM       = addr_op[ADDR_W*i +: ADDR_W];
        HAUSERM      = auser_op[USER_W*i +: USER_W];
      end
    end
  end

  // Write-data mux follows the data-phase owner, not the current grant.
  always_comb begin
    HWDATAM = '0;
    HWUSERM = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (data_in_port_q == PORT_W'(i)) begin
        HWDATAM = wdata_op[DATA_W*i +: DATA_W];
        HWUSERM = wuser_op[USER_W*i +: USER_W];
      end
    end
  end

  // Lock tracking and next-grant decision.
  always_comb begin
    hsel_lock_d    = hsel_lock_q;
    addr_in_port_d = addr_in_port_q;
    no_port_d      = no_port_q;
    found          = 1'b0;
    rr_idx         = 0;

    if (HSELM && HTRANSM[1] && HMASTLOCKM)
      hsel_lock_d = 1'b1;
    else if (!HMASTLOCKM)
      hsel_lock_d = 1'b0;

    // hsel_lock covers IDLE cycles with HSEL low inside a locked sequence.
    hlock_arb  = HMASTLOCKM & (hsel_lock_q | HSELM);
    burst_hold = !no_port_q && ((HTRANSM == TRN_BUSY) || (HTRANSM == TRN_SEQ));

    if (!hlock_arb && !burst_hold) begin
`ifdef AHB_OUT_STAGE_FIXED_PRIO_EN
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i]) begin
          found          = 1'b1;
          addr_in_port_d = PORT_W'(i);
        end
      end
`else
      // Offsets 1..NUM_PORTS: current owner is visited last.
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        rr_idx = (32'(addr_in_port_q) + k) % NUM_PORTS;
        if (!found && req[rr_idx[PORT_W-1:0]]) begin
          found          = 1'b1;
          addr_in_port_d = rr_idx[PORT_W-1:0];
        end
      end
`endif
      // With no requester the index parks at its previous value.
      no_port_d = !found;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_in_port_q <= '0;
      no_port_q      <= 1'b1;
      data_in_port_q <= '0;
      slave_sel_q    <= 1'b0;
      hsel_lock_q    <= 1'b0;
    end else if (HREADYMUXM) begin
      addr_in_port_q <= addr_in_port_d;
      no_port_q      <= no_port_d;
      data_in_port_q <= addr_in_port_q;
      slave_sel_q    <= HSELM;
      hsel_lock_q    <= hsel_lock_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_matrix_out_stage_n.sv
// tb_ahb_bus_matrix_out_stage_n
//   Scoreboard bench for a 4-port output stage. The stimulus process drives
//   one cycle at a time and queues the expected outputs for that cycle; a
//   monitor on the falling edge pops and compares them.
//   Expected grant sequences depend on AHB_OUT_STAGE_FIXED_PRIO_EN.
module tb_ahb_bus_matrix_out_stage_n;

  localparam int NP = 4;

  typedef enum logic [1:0] {
    T_IDLE   = 2'b00,
    T_BUSY   = 2'b01,
    T_NONSEQ = 2'b10,
    T_SEQ    = 2'b11
  } htrans_e;

  typedef struct {
    int         cyc;
    int         port;   // -1: no owner
    logic       hsel;
    logic [1:0] trans;
    logic       lock;
    logic       rdy;
    int         dport;
  } exp_t;

  logic HCLK, HRESETn, HREADYOUTM;
  logic [NP-1:0]    sel_op, held_tran_op, write_op, mastlock_op;
  logic [2*NP-1:0]  trans_op;
  logic [3*NP-1:0]  size_op, burst_op;
  logic [4*NP-1:0]  prot_op, master_op;
  logic [32*NP-1:0] addr_op, auser_op, wuser_op, wdata_op;
  logic [NP-1:0]    active_op;
  logic HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM, HMASTERM;
  logic [31:0] HADDRM, HAUSERM, HWDATAM, HWUSERM;

  logic [NP-1:0] sel_a, lock_a;
  logic [1:0]    trans_a [NP];
  localparam logic [NP-1:0] WRITE_PAT = 4'b0101;

  exp_t sb[$];
  exp_t mon_r;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   a_g[4], a_d[4], d_g[4], d_d[4];
  int   park_b, park_e;

  ahb_bus_matrix_out_stage_n #(
    .NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .USER_W(32)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .sel_op(sel_op), .held_tran_op(held_tran_op), .write_op(write_op),
    .mastlock_op(mastlock_op), .trans_op(trans_op), .size_op(size_op),
    .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
    .addr_op(addr_op), .auser_op(auser_op), .wuser_op(wuser_op),
    .wdata_op(wdata_op), .HREADYOUTM(HREADYOUTM), .active_op(active_op),
    .HSELM(HSELM), .HWRITEM(HWRITEM), .HMASTLOCKM(HMASTLOCKM),
    .HREADYMUXM(HREADYMUXM), .HTRANSM(HTRANSM), .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM),
    .HADDRM(HADDRM), .HAUSERM(HAUSERM), .HWDATAM(HWDATAM), .HWUSERM(HWUSERM)
  );

  function automatic logic [31:0] port_addr(input int p);
    return 32'hA000_0000 + 32'(p) * 32'h100;
  endfunction

  function automatic logic [31:0] port_wdata(input int p);
    return 32'hD000_0000 + 32'(p) * 32'h11;
  endfunction

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      sel_op[i]          = sel_a[i];
      held_tran_op[i]    = sel_a[i];
      mastlock_op[i]     = lock_a[i];
      write_op[i]        = WRITE_PAT[i];
      trans_op[2*i +: 2] = trans_a[i];
      size_op[3*i +: 3]  = 3'b010;
      burst_op[3*i +: 3] = (i == 1) ? 3'b011 : 3'b000;
      prot_op[4*i +: 4]  = 4'b0011;
      master_op[4*i +: 4] = 4'(i);
      addr_op[32*i +: 32]  = port_addr(i);
      auser_op[32*i +: 32] = 32'h0;
      wuser_op[32*i +: 32] = 32'h0;
      wdata_op[32*i +: 32] = port_wdata(i);
    end
  end

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got 0x%0h required 0x%0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge HCLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_r = sb.pop_front();
      if (mon_r.cyc != cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL stale cyc=%0d: got cycle %0d required cycle %0d", cyc, cyc, mon_r.cyc);
      end else begin
        chk("active", 32'(active_op), (mon_r.port < 0) ? 32'h0 : (32'h1 << mon_r.port));
        chk("hsel",   32'(HSELM), 32'(mon_r.hsel));
        chk("htrans", 32'(HTRANSM), 32'(mon_r.trans));
        chk("mlock",  32'(HMASTLOCKM), 32'(mon_r.lock));
        chk("hready", 32'(HREADYMUXM), 32'(mon_r.rdy));
        chk("haddr",  HADDRM, (mon_r.port < 0) ? 32'h0 : port_addr(mon_r.port));
        chk("hmaster", 32'(HMASTERM), (mon_r.port < 0) ? 32'h0 : 32'(mon_r.port));
        chk("hwrite", 32'(HWRITEM), (mon_r.port < 0) ? 32'h0 : 32'(WRITE_PAT[mon_r.port]));
        chk("hwdata", HWDATAM, port_wdata(mon_r.dport));
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input int p, input logic s, input logic [1:0] t, input logic lk);
    sel_a[p]   = s;
    trans_a[p] = t;
    lock_a[p]  = lk;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      for (int i = 0; i < NP; i++) drive(i, 1'b0, T_IDLE, 1'b0);
    end
  endtask

  task automatic expect_c(input int port, input logic hs, input logic [1:0] tr,
                          input logic lk, input logic rdy, input int dport);
    exp_t r;
    r.cyc = cyc; r.port = port; r.hsel = hs; r.trans = tr;
    r.lock = lk; r.rdy = rdy; r.dport = dport;
    sb.push_back(r);
  endtask

  initial begin
`ifdef AHB_OUT_STAGE_FIXED_PRIO_EN
    a_g = '{0, 0, 0, 0}; a_d = '{0, 0, 0, 0};
    d_g = '{1, 1, 1, 1}; d_d = '{1, 1, 1, 1};
    park_b = 0; park_e = 1;
`else
    // Parked index 0 after reset: the search starts at port 1, so 2 wins first.
    a_g = '{2, 0, 2, 0}; a_d = '{0, 2, 0, 2};
    d_g = '{3, 1, 3, 1}; d_d = '{1, 3, 1, 3};
    park_b = 2; park_e = 3;
`endif
    HRESETn = 1'b0; HREADYOUTM = 1'b1;
    sel_a = '0; lock_a = '0;
    for (int i = 0; i < NP; i++) trans_a[i] = T_IDLE;

    // Reset state
    tick(); tick();
    expect_c(-1, 0, T_IDLE, 0, 1, 0);
    HRESETn = 1'b1;
    tick();
    expect_c(-1, 0, T_IDLE, 0, 1, 0);

    // Ports 0 and 2 request single NONSEQ transfers together
    tick();
    drive(0, 1, T_NONSEQ, 0); drive(2, 1, T_NONSEQ, 0);
    expect_c(-1, 0, T_IDLE, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_c(a_g[i], 1, T_NONSEQ, 0, 1, a_d[i]);
    end
    idle(2);

    // Port 1 INCR4 with two wait states, port 3 requesting from beat 2
    tick(); drive(1, 1, T_NONSEQ, 0); expect_c(-1, 0, T_IDLE, 0, 1, park_b);
    tick(); expect_c(1, 1, T_NONSEQ, 0, 1, park_b);
    tick(); drive(1, 1, T_SEQ, 0); drive(3, 1, T_NONSEQ, 0);
    expect_c(1, 1, T_SEQ, 0, 1, 1);
    tick(); expect_c(1, 1, T_SEQ, 0, 1, 1);
    tick(); HREADYOUTM = 1'b0; expect_c(1, 1, T_SEQ, 0, 0, 1);
    tick(); expect_c(1, 1, T_SEQ, 0, 0, 1);
    tick(); HREADYOUTM = 1'b1; expect_c(1, 1, T_SEQ, 0, 1, 1);
    tick(); drive(1, 0, T_IDLE, 0); expect_c(1, 0, T_IDLE, 0, 1, 1);
    tick(); expect_c(3, 1, T_NONSEQ, 0, 1, 1);
    idle(2);

    // Port 0 locked sequence with an HSEL-low IDLE cycle, port 1 waiting
    tick(); drive(0, 1, T_NONSEQ, 1); expect_c(-1, 0, T_IDLE, 0, 1, 3);
    tick(); drive(1, 1, T_NONSEQ, 0); expect_c(0, 1, T_NONSEQ, 1, 1, 3);
    tick(); drive(0, 0, T_IDLE, 1);   expect_c(0, 0, T_IDLE, 1, 1, 0);
    tick(); drive(0, 1, T_NONSEQ, 1); expect_c(0, 1, T_NONSEQ, 1, 1, 0);
    tick(); drive(0, 0, T_IDLE, 0);   expect_c(0, 0, T_IDLE, 0, 1, 0);
    tick(); expect_c(1, 1, T_NONSEQ, 0, 1, 0);
    idle(2);

    // Ports 1 and 3 request continuously
    tick();
    drive(1, 1, T_NONSEQ, 0); drive(3, 1, T_NONSEQ, 0);
    expect_c(-1, 0, T_IDLE, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_c(d_g[i], 1, T_NONSEQ, 0, 1, d_d[i]);
    end
    idle(2);

    // Reset during a port 2 data phase held by a wait state
    tick(); drive(2, 1, T_NONSEQ, 0); expect_c(-1, 0, T_IDLE, 0, 1, park_e);
    tick(); expect_c(2, 1, T_NONSEQ, 0, 1, park_e);
    tick(); drive(2, 0, T_IDLE, 0); HREADYOUTM = 1'b0; HRESETn = 1'b0;
    expect_c(2, 0, T_IDLE, 0, 0, 2);
    tick(); HRESETn = 1'b1; expect_c(-1, 0, T_IDLE, 0, 1, 0);
    tick(); HREADYOUTM = 1'b1; expect_c(-1, 0, T_IDLE, 0, 1, 0);
    tick(); tick();

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
